// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end.
// Contents:
//   rx_state_e  - receiver FSM state encoding
//   DATA_BITS   - data bits per frame (8)
//   STOP_BITS   - stop bits per frame (1)
//   calc_div    - clocks per bit, integer-truncated clk_freq / baud
//   calc_half   - clocks per half bit, used to centre the start-bit sample
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_freq,
                                            input int unsigned baud);
    return calc_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO for the received bytes.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   i_push, i_din     - write request and data
//   i_pop             - read request (ignored when empty)
//   o_dout            - head entry, combinational; 0 while empty
//   o_full, o_empty   - occupancy flags
//   o_count           - entries stored, 0..2^addr_w
// A push while full is accepted only if a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned addr_w = 4,
  parameter int unsigned data_w = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [data_w-1:0] i_din,
  input  logic              i_pop,
  output logic [data_w-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [addr_w:0]   o_count
);

  localparam int unsigned DEPTH = 1 << addr_w;

  logic [data_w-1:0] r_mem [DEPTH];
  logic [addr_w-1:0] r_wr_ptr;
  logic [addr_w-1:0] r_rd_ptr;
  logic [addr_w:0]   r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_full    = (r_count == (addr_w + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; entries are only read after
  // being written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a byte FIFO and sticky error flags.
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   uart_rxd   - asynchronous serial input, idle high
//   rx_data    - FIFO head byte (0 while empty)
//   rx_avail   - FIFO not empty
//   rx_ack     - pop head byte; ignored when empty
//   rx_count   - bytes stored
//   overrun    - sticky: good byte dropped on a full FIFO
//   frame_err  - sticky: stop bit sampled low
//   err_clr    - pulse clearing both sticky flags (a same-cycle set wins)
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned clk_freq       = 50_000_000,
  parameter int unsigned uart_baud_rate = 115_200,
  parameter int unsigned addr_w         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rxd,
  output logic [7:0]      rx_data,
  output logic            rx_avail,
  input  logic            rx_ack,
  output logic [addr_w:0] rx_count,
  output logic            overrun,
  output logic            frame_err,
  input  logic            err_clr
);

  localparam int unsigned DIV  = calc_div(clk_freq, uart_baud_rate);
  localparam int unsigned HALF = calc_half(clk_freq, uart_baud_rate);
  localparam int unsigned TW   = $clog2(DIV);
  localparam int unsigned BW   = $clog2(DATA_BITS);

  localparam logic [TW-1:0] DIV_M1   = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 w_rxs;
  rx_state_e            r_state,  w_state_n;
  logic [TW-1:0]        r_timer,  w_timer_n;
  logic [BW-1:0]        r_bit,    w_bit_n;
  logic [DATA_BITS-1:0] r_shift,  w_shift_n;
  logic                 r_brk,    w_brk_n;
  logic                 w_push;
  logic                 w_ferr_evt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], uart_rxd};
  end
  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_brk   <= w_brk_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_n  = r_state;
    w_timer_n  = r_timer + TW'(1);
    w_bit_n    = r_bit;
    w_shift_n  = r_shift;
    w_brk_n    = r_brk;
    w_push     = 1'b0;
    w_ferr_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        if (!w_rxs) w_state_n = S_START;
      end
      S_START: begin
        // Re-check the line mid start bit to reject glitches.
        if (r_timer == HALF_M1) begin
          w_timer_n = '0;
          if (!w_rxs) begin
            w_state_n = S_DATA;
            w_bit_n   = '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_timer == DIV_M1) begin
          w_timer_n = '0;
          w_shift_n = {w_rxs, r_shift[DATA_BITS-1:1]};   // LSB first
          if (r_bit == BIT_LAST) w_state_n = S_STOP;
          else                   w_bit_n   = r_bit + 1'b1;
        end
      end
      S_STOP: begin
        if (r_brk) begin
          // Hold here through a break so it raises only one error.
          w_timer_n = r_timer;
          if (w_rxs) begin
            w_brk_n   = 1'b0;
            w_state_n = S_IDLE;
          end
        end else if (r_timer == DIV_M1) begin
          w_timer_n = '0;
          if (w_rxs) begin
            w_push    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_evt = 1'b1;
            w_brk_n    = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  sync_fifo #(
    .addr_w (addr_w),
    .data_w (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (r_shift),
    .i_pop   (rx_ack),
    .o_dout  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (rx_count)
  );

  assign rx_avail = ~w_empty;
  // When full the FIFO is non-empty, so rx_ack alone decides whether a pop
  // makes room for the incoming byte.
  assign w_drop   = w_push & w_full & ~rx_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= w_drop     | (overrun   & ~err_clr);
      frame_err <= w_ferr_evt | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. The DUT runs at a faster baud rate
// than the default so the whole sequence stays within a short run; the bit
// time is derived from the same truncating divisor rule.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CLK_NS   = 20;
  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 1_150_000;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned DIV_TB   = CLK_FREQ / BAUD;
  localparam int unsigned BIT_NS   = DIV_TB * CLK_NS;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            uart_rxd = 1'b1;
  logic            rx_ack   = 1'b0;
  logic            err_clr  = 1'b0;
  logic [7:0]      rx_data;
  logic            rx_avail;
  logic [ADDR_W:0] rx_count;
  logic            overrun;
  logic            frame_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bytes the receiver should hold, in order.
  logic [7:0] model_q [$];
  logic       exp_overrun   = 1'b0;
  logic       exp_frame_err = 1'b0;

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx_fifo #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD),
    .addr_w         (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_ack    (rx_ack),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else                        exp_overrun = 1'b1;
  endfunction

  task automatic send_bits(input logic [7:0] b);
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #(BIT_NS);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b);
    uart_rxd = 1'b1;
    #(BIT_NS);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_count"},   rx_count, 32'(model_q.size()));
    check({tag, "_avail"},   rx_avail, (model_q.size() != 0));
    check({tag, "_overrun"}, overrun,  exp_overrun);
    check({tag, "_ferr"},    frame_err, exp_frame_err);
  endtask

  task automatic pop_check(input string tag, output logic [7:0] got);
    logic [7:0] exp;
    @(negedge clk);
    exp = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
    got = rx_data;
    check({tag, "_avail"}, rx_avail, 1'b1);
    check({tag, "_data"},  rx_data,  exp);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_overrun   = 1'b0;
    exp_frame_err = 1'b0;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] got;
    logic [7:0] last;
    logic [7:0] b17;
    longint     t0;
    longint     t_av;
    logic       seen;

    // Reset values while rst is held low.
    #40;
    check("rst_avail",   rx_avail,  1'b0);
    check("rst_count",   rx_count,  32'd0);
    check("rst_data",    rx_data,   32'd0);
    check("rst_overrun", overrun,   1'b0);
    check("rst_ferr",    frame_err, 1'b0);
    #40;
    rst = 1'b1;

    // Idle line, then an ack on an empty FIFO.
    #(100_000);
    check_state("idle");
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check_state("ack_empty");

    // Single 0xA5 frame with latency window around 9.5 bit times.
    t0   = $time;
    t_av = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5);
      begin
        int k;
        k = 0;
        while (!rx_avail && k < 40 * DIV_TB) begin
          @(negedge clk);
          k++;
        end
        t_av = $time;
        seen = rx_avail;
      end
    join
    model_push(8'hA5);
    check("a5_avail_seen", seen, 1'b1);
    check("a5_latency",
          ((t_av - t0) >= longint'(93 * BIT_NS / 10)) &&
          ((t_av - t0) <= longint'(98 * BIT_NS / 10)), 1'b1);
    check_state("a5");
    pop_check("a5_pop", got);
    check_state("a5_popped");

    // Short low glitch is a false start; a following frame still decodes.
    uart_rxd = 1'b0;
    #(BIT_NS / 4);
    uart_rxd = 1'b1;
    #(3 * BIT_NS);
    check_state("glitch");
    b = 8'($urandom);
    send_frame(b);
    model_push(b);
    check_state("after_glitch");
    pop_check("after_glitch_pop", got);

    // 0x3C with a stop bit held low for 5 bit times: one error only.
    send_bits(8'h3C);
    uart_rxd = 1'b0;
    #(2 * BIT_NS);
    exp_frame_err = 1'b1;
    check_state("break");
    pulse_err_clr();
    check_state("break_clr");
    #(3 * BIT_NS);
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    check_state("break_single");

    // Random frames with random pops.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_push(b);
      if (model_q.size() != 0 && $urandom_range(0, 1) == 1)
        pop_check("rnd_pop", got);
    end
    check_state("rnd");
    while (model_q.size() != 0) pop_check("rnd_drain", got);
    check_state("rnd_drained");

    // 17 bytes without acks: the last is dropped and overrun set.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i));
      model_push(8'(i));
    end
    check_state("overrun");
    for (int i = 0; i < 16; i++) pop_check("ovr_pop", got);
    check_state("ovr_drained");
    pulse_err_clr();
    check_state("ovr_clr");

    // Full FIFO with an ack in the exact push cycle of the 17th byte.
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_push(b);
    end
    check_state("full");
    b17  = 8'($urandom);
    seen = 1'b0;
    fork
      send_frame(b17);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!dut.w_push && k < 20 * DIV_TB) begin
          @(negedge clk);
          k++;
        end
        seen = dut.w_push;
        check("simul_head", rx_data, model_q[0]);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    check("simul_push_seen", seen, 1'b1);
    void'(model_q.pop_front());
    model_push(b17);
    check_state("simul");
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pop_check("simul_pop", got);
      last = got;
    end
    check("simul_last", last, b17);
    check_state("simul_drained");

    // Reset in the middle of a frame: partial byte never appears.
    b = 8'($urandom);
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = b[i];
      #(BIT_NS);
    end
    rst = 1'b0;
    uart_rxd = 1'b1;
    #(100);
    rst = 1'b1;
    #(15 * BIT_NS);
    check_state("mid_rst");
    b = 8'($urandom);
    send_frame(b);
    model_push(b);
    check_state("post_rst");
    pop_check("post_rst_pop", got);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end that sits directly downstream of the board-level uart_rxd pin and upstream of the system's UART bus register.
- Synchronises the asynchronous RX line, deserialises 8N1 frames at a fixed baud rate, and buffers received bytes in a FIFO.
- Exposes a valid/ack pop interface plus sticky error flags for the register file.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- uart_baud_rate, 115200, line baud rate.
- addr_w, 4, log2 of FIFO depth (depth = 2^addr_w = 16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- uart_rxd  input  1  asynchronous serial line, idle high.
- rx_data  output  8  byte at the FIFO head; valid only while rx_avail=1.
- rx_avail  output  1  FIFO not empty.
- rx_ack  input  1  pop the head byte; ignored when rx_avail=0.
- rx_count  output  addr_w+1  number of bytes stored, 0..2^addr_w.
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- err_clr  input  1  one-cycle pulse that clears overrun and frame_err.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; FIFO empty; rx_avail=0, rx_count=0, rx_data=0, overrun=0, frame_err=0. The synchroniser flops reset to 1 (line idle).
- Divisor constants:
  - DIV = clk_freq/uart_baud_rate, integer truncation (434 at the defaults).
  - HALF = DIV/2 (217).
  - The bit counter is wide enough for DIV-1.
- uart_rxd passes through a 2-flop synchroniser; the FSM sees only the synchronised value rxs (2-cycle latency).
- FSM states:
  - IDLE: the first cycle with rxs=0 goes to START and loads the timer to 0.
  - START: at timer=HALF-1, if rxs=0 go to DATA with bit index 0 and reset the timer. Otherwise this is a false start; return to IDLE and record nothing.
  - DATA: at each timer=DIV-1, shift rxs into the shift register LSB-first. After bit 7 go to STOP.
  - STOP: at timer=DIV-1, sample rxs.
    - rxs=1: push the byte (or drop it, see FIFO full). Go to IDLE.
    - rxs=0: set frame_err and discard the byte. Go to IDLE only once rxs=1, so a break condition generates exactly one error.
- Push timing: on the push cycle the byte is written; rx_avail and rx_count update on the next clock edge.
- FIFO:
  - Circular buffer, 2^addr_w entries.
  - Read and write pointers are addr_w bits wide and wrap modulo depth; rx_count is a separate counter.
  - rx_data is the combinational read at the read pointer.
- Pop: rx_ack=1 with rx_avail=1 advances the read pointer at the clock edge. rx_ack with the FIFO empty has no effect.
- Simultaneous push and pop:
  - FIFO not full: both occur and rx_count is unchanged.
  - FIFO full: the pop frees a slot, so the push is accepted and overrun is not set.
- Push when full without a pop: the byte is dropped, overrun is set, and the FIFO contents are unchanged.
- err_clr:
  - Clears both flags at the next edge.
  - If a new error event occurs in the same cycle, the set wins and the flag stays 1.
- An asynchronous reset mid-frame aborts the frame; the partial byte is never pushed.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the function computing DIV and HALF from clk_freq and uart_baud_rate;
  - the frame constants: 8 data bits, 1 stop bit.
- One sub-module, sync_fifo: parameter addr_w, data width 8.
  - Push/pop/full/empty/count interface.
  - Same clk/rst convention.
- The FSM, synchroniser, and error flags stay in uart_rx_fifo.

Test Plan:
1. Release rst after 80 ns, keep the line idle for 1 ms -> rx_avail=0, rx_count=0, no flags set.
2. Drive frame 0xA5, 8N1, bit time 8680 ns -> rx_avail=1 about 9.5 bit times after the start edge; rx_data=0xA5, rx_count=1. Pulse rx_ack -> rx_avail=0, rx_count=0.
3. Drive a 2 µs low glitch on the idle line -> no byte pushed, frame_err=0, FSM back in IDLE.
4. Drive 0x3C with the stop bit held low for 5 bit times -> frame_err=1, rx_count=0, exactly one error. Pulse err_clr -> frame_err=0.
5. Send 17 bytes 0x00..0x10 with no rx_ack -> rx_count=16, overrun=1. Popping 16 times returns 0x00..0x0F in order; 0x10 is lost.
6. FIFO full (16 bytes); assert rx_ack in the exact cycle of the 17th push -> overrun=0, rx_count stays 16, and the last entry read out is the 17th byte.
